// File: rtl/ringosc_freq_meter_pkg.sv
// Shared types and default sizes for the ring-oscillator frequency meter.
// Measurement FSM encoding plus default counter/synchroniser dimensions.
package ringosc_meter_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int GATE_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } meter_state_t;

endpackage

// File: rtl/ringosc_freq_meter_if.sv
// Control/result bundle of the frequency meter: the master requests windows,
// the slave (the meter) reports busy/done and the latest count.
interface ringosc_freq_meter_if
    import ringosc_meter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) ();

    logic              ena;
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output ena, start, gate_cycles,
        input  busy, done, count, overflow
    );

    modport slave (
        input  ena, start, gate_cycles,
        output busy, done, count, overflow
    );

endinterface

// File: rtl/ringosc_freq_meter_sync_edge.sv
// Resynchronises the asynchronous oscillator tap into the clk domain and
// emits a one-cycle pulse on each synchronised rising edge.
module ringosc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Gated frequency counter: counts synchronised oscillator edges over N clk cycles.
// Define FREQ_METER_CONTINUOUS_EN for free-running back-to-back windows.
module ringosc_freq_meter
    import ringosc_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  osc_in,
    ringosc_freq_meter_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_t      state;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic              sat_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              edge_pulse;
    logic [CNT_W-1:0]  edge_cnt_nxt;
    logic              sat_nxt;
`ifdef FREQ_METER_CONTINUOUS_EN
    logic [GATE_W-1:0] gate_n_q;
`endif

    ringosc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (osc_in),
        .edge_pulse (edge_pulse)
    );

    // Saturating count including the current cycle, so the last gate cycle's edge is kept
    always_comb begin
        edge_cnt_nxt = edge_cnt_q;
        sat_nxt      = sat_q;
        if (state == GATE && edge_pulse) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_cnt_nxt = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef FREQ_METER_CONTINUOUS_EN
            gate_n_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && !bus.ena) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.ena && bus.start) begin
                            state      <= ARM;
                            busy_q     <= 1'b1;
                            gate_cnt_q <= bus.gate_cycles;
                            edge_cnt_q <= '0;
                            sat_q      <= 1'b0;
`ifdef FREQ_METER_CONTINUOUS_EN
                            gate_n_q   <= bus.gate_cycles;
`endif
                        end
                    end
                    ARM: begin
                        if (gate_cnt_q != '0) begin
                            state <= GATE;
                        end else begin
                            state      <= DONE;
                            count_q    <= edge_cnt_q;
                            overflow_q <= sat_q;
                            done_q     <= 1'b1;
                        end
                    end
                    GATE: begin
                        edge_cnt_q <= edge_cnt_nxt;
                        sat_q      <= sat_nxt;
                        if (gate_cnt_q == GATE_W'(1)) begin
                            state      <= DONE;
                            count_q    <= edge_cnt_nxt;
                            overflow_q <= sat_nxt;
                            done_q     <= 1'b1;
                        end else begin
                            gate_cnt_q <= gate_cnt_q - GATE_W'(1);
                        end
                    end
                    DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
                        state      <= ARM;
                        gate_cnt_q <= gate_n_q;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
`else
                        state  <= IDLE;
                        busy_q <= 1'b0;
`endif
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed self-checking bench for ringosc_freq_meter (16-bit and 4-bit count instances).
// Covers FREQ_METER_CONTINUOUS_EN when the macro is defined, single-shot otherwise.
`timescale 1ns/1ps
module tb_ringosc_freq_meter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic osc   = 1'b0;
    int   osc_half = 50;
    int   checks = 0;
    int   errors = 0;

    ringosc_freq_meter_if #(.CNT_W(16), .GATE_W(16)) mif ();
    ringosc_freq_meter_if #(.CNT_W(4),  .GATE_W(16)) sif ();

    ringosc_freq_meter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc),
        .bus    (mif)
    );

    ringosc_freq_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc),
        .bus    (sif)
    );

    always #5 clk = ~clk;

    // Oscillator edges sit 2 ns off the clock grid so sampling never races
    initial begin
        #2;
        forever begin
            #(osc_half) osc = ~osc;
        end
    end

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mif.ena = 1'b0;
        settle(2);
        mif.ena = 1'b1;
    endtask

    task automatic measure(input int n, input int limit, output logic busy1, output int first_k,
                           output int n_done, output logic [15:0] cnt, output logic ovf);
        first_k = -1;
        n_done  = 0;
        cnt     = '0;
        ovf     = 1'b0;
        busy1   = 1'b0;
        @(negedge clk);
        mif.gate_cycles = 16'(n);
        mif.start       = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mif.start = 1'b0;
                busy1     = mif.busy;
            end
            if (mif.done === 1'b1) begin
                n_done++;
                if (first_k < 0) begin
                    first_k = k;
                    cnt     = mif.count;
                    ovf     = mif.overflow;
                end
            end
        end
    endtask

    task automatic test_reset();
        mif.ena = 1'b0; mif.start = 1'b0; mif.gate_cycles = '0;
        sif.ena = 1'b0; sif.start = 1'b0; sif.gate_cycles = '0;
        rst_n = 1'b0;
        settle(3);
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", mif.busy); end
        checks++; if (mif.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", mif.done); end
        checks++; if (mif.count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", mif.count); end
        checks++; if (mif.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", mif.overflow); end
        checks++; if (sif.count !== 4'd0) begin errors++; $display("[TB] FAIL reset_sat_count got %0d want 0", sif.count); end
        rst_n = 1'b1;
        settle(2);
    endtask

    task automatic test_basic();
        logic busy1; int first_k; int n_done; logic [15:0] cnt; logic ovf;
        osc_half = 50;
        mif.ena  = 1'b1;
        settle(30);
        measure(100, 102, busy1, first_k, n_done, cnt, ovf);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy1); end
        checks++; if (first_k != 102) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d want 102", first_k); end
        checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL basic_done_pulses got %0d want 1", n_done); end
        checks++; if (cnt !== 16'd10) begin errors++; $display("[TB] FAIL basic_count got %0d want 10", cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_overflow got %b want 0", ovf); end
        idle_cycle();
    endtask

    task automatic test_saturate();
        int first_k = -1;
        logic [3:0] cnt = '0;
        logic ovf = 1'b0;
        osc_half = 20;
        settle(30);
        @(negedge clk);
        sif.ena = 1'b1; sif.gate_cycles = 16'd100; sif.start = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (k == 1) sif.start = 1'b0;
            if (sif.done === 1'b1 && first_k < 0) begin
                first_k = k; cnt = sif.count; ovf = sif.overflow;
            end
        end
        checks++; if (first_k != 102) begin errors++; $display("[TB] FAIL sat_done_cycle got %0d want 102", first_k); end
        checks++; if (cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_count got %0d want 15", cnt); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL sat_overflow got %b want 1", ovf); end
        checks++; if (sif.busy !== 1'b0 && sif.busy !== 1'b1) begin errors++; $display("[TB] FAIL sat_busy_known got %b want 0/1", sif.busy); end
        sif.ena = 1'b0;
        settle(3);
    endtask

    task automatic test_abort();
        int n_done = 0;
        logic busy_after = 1'b1;
        osc_half = 50;
        settle(30);
        @(negedge clk);
        mif.gate_cycles = 16'd200; mif.start = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 1) mif.start = 1'b0;
            if (mif.done === 1'b1) n_done++;
            if (k == 51) mif.ena = 1'b0;
            if (k == 52) busy_after = mif.busy;
        end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy_after); end
        checks++; if (n_done != 0) begin errors++; $display("[TB] FAIL abort_done_pulses got %0d want 0", n_done); end
        checks++; if (mif.count !== 16'd10) begin errors++; $display("[TB] FAIL abort_count_hold got %0d want 10", mif.count); end
        checks++; if (mif.overflow !== 1'b0) begin errors++; $display("[TB] FAIL abort_overflow_hold got %b want 0", mif.overflow); end
        mif.ena = 1'b1;
        settle(2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mif.gate_cycles = 16'd100; mif.start = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (k == 1) mif.start = 1'b0;
            if (k == 30) rst_n = 1'b0;
        end
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", mif.busy); end
        checks++; if (mif.count !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_count got %0d want 0", mif.count); end
        checks++; if (mif.overflow !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_overflow got %b want 0", mif.overflow); end
        rst_n = 1'b1;
        settle(30);
    endtask

    task automatic test_start_while_busy();
        int first_k = -1;
        int n_done = 0;
        logic [15:0] cnt = '0;
        @(negedge clk);
        mif.gate_cycles = 16'd100; mif.start = 1'b1;
        for (int k = 1; k <= 102; k++) begin
            @(negedge clk);
            if (k == 1) mif.start = 1'b0;
            if (k == 40) begin mif.start = 1'b1; mif.gate_cycles = 16'd5; end
            if (k == 41) mif.start = 1'b0;
            if (mif.done === 1'b1) begin
                n_done++;
                if (first_k < 0) begin first_k = k; cnt = mif.count; end
            end
        end
        checks++; if (first_k != 102) begin errors++; $display("[TB] FAIL busystart_done_cycle got %0d want 102", first_k); end
        checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL busystart_done_pulses got %0d want 1", n_done); end
        checks++; if (cnt !== 16'd10) begin errors++; $display("[TB] FAIL busystart_count got %0d want 10", cnt); end
        idle_cycle();
    endtask

    task automatic test_zero_gate();
        logic busy1; int first_k; int n_done; logic [15:0] cnt; logic ovf;
        measure(0, 2, busy1, first_k, n_done, cnt, ovf);
        checks++; if (first_k != 2) begin errors++; $display("[TB] FAIL zero_done_cycle got %0d want 2", first_k); end
        checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL zero_done_pulses got %0d want 1", n_done); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL zero_count got %0d want 0", cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL zero_overflow got %b want 0", ovf); end
        idle_cycle();
    endtask

`ifdef FREQ_METER_CONTINUOUS_EN
    task automatic test_back_to_back();
        int done_k[$];
        int late_done = 0;
        osc_half = 40;
        settle(30);
        @(negedge clk);
        mif.gate_cycles = 16'd64; mif.start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) mif.start = 1'b0;
            if (mif.done === 1'b1) begin
                if (k <= 200) begin
                    done_k.push_back(k);
                    checks++;
                    if (mif.count !== 16'd8) begin errors++; $display("[TB] FAIL cont_count at %0d got %0d want 8", k, mif.count); end
                end else begin
                    late_done++;
                end
            end
            if (k == 200) mif.ena = 1'b0;
        end
        checks++; if (done_k.size() != 3) begin errors++; $display("[TB] FAIL cont_done_pulses got %0d want 3", done_k.size()); end
        for (int i = 0; i < done_k.size() && i < 3; i++) begin
            checks++;
            if (done_k[i] != 66 * (i + 1)) begin errors++; $display("[TB] FAIL cont_done_cycle[%0d] got %0d want %0d", i, done_k[i], 66 * (i + 1)); end
        end
        checks++; if (late_done != 0) begin errors++; $display("[TB] FAIL cont_stop_done got %0d want 0", late_done); end
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_stop_busy got %b want 0", mif.busy); end
    endtask
`else
    task automatic test_single_shot();
        logic busy1; int first_k; int n_done; logic [15:0] cnt; logic ovf;
        osc_half = 40;
        settle(30);
        measure(64, 200, busy1, first_k, n_done, cnt, ovf);
        checks++; if (first_k != 66) begin errors++; $display("[TB] FAIL single_done_cycle got %0d want 66", first_k); end
        checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL single_done_pulses got %0d want 1", n_done); end
        checks++; if (cnt !== 16'd8) begin errors++; $display("[TB] FAIL single_count got %0d want 8", cnt); end
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got %b want 0", mif.busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_abort();
        test_reset_mid();
        test_start_while_busy();
        test_zero_gate();
`ifdef FREQ_METER_CONTINUOUS_EN
        test_back_to_back();
`else
        test_single_shot();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
